// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker for the 16-bit XNOR LFSR stream
//
// Purpose:
//   Receives the serial bit stream of the 16-bit XNOR LFSR generator
//   (feedback = ~(s[15]^s[14]^s[12]^s[3]) shifted into the LSB), locks onto
//   it, then counts checked bits and bit errors for BER measurement.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - din valid; all state advances only when en=1
//   din       - received serial bit
//   clr       - synchronous clear of err_count / bit_count only
//   locked    - checker synchronised to the stream
//   err_pulse - one-cycle pulse per error detected while locked
//   err_count - saturating count of errors detected while locked
//   bit_count - saturating count of bits checked while locked
module lfsr_checker #(
    parameter int LOCK_MATCHES = 32,
    parameter int LOSS_ERRORS  = 8,
    parameter int LOSS_WINDOW  = 128,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int FILL_W  = 5;
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_ERRORS + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = 5'd16;
    // Terminal values are compared before incrementing so the counters never
    // need to represent the parameter value itself.
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERRORS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [15:0]        LOCKUP     = 16'hFFFF;

    state_t             state_q, state_d;
    logic [15:0]        r_q, r_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    logic pred;
    logic miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        pred = ~(r_q[15] ^ r_q[14] ^ r_q[12] ^ r_q[3]);
        miss = (din != pred);

        if (en) begin
            case (state_q)
                SEARCH: begin
                    r_d = {r_q[14:0], din};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (!miss && (r_q != LOCKUP)) begin
                        // All-ones is the XNOR lock-up state: it predicts 1
                        // forever, so a stuck-high line must never count.
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Free-run on our own prediction so a bad bit cannot
                    // corrupt the register and cascade into later errors.
                    r_d = {r_q[14:0], pred};
                    bit_count_d = (bit_count_q == CNT_MAX) ? bit_count_q
                                                           : bit_count_q + CNT_W'(1);
                    if (miss) begin
                        err_pulse_d = 1'b1;
                        err_count_d = (err_count_q == CNT_MAX) ? err_count_q
                                                               : err_count_q + CNT_W'(1);
                    end
                    // Loss is evaluated before rollover so an error on the
                    // last bit of a window still belongs to that window.
                    if (miss && (werr_q == WERR_LAST)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_q + WERR_W'(miss);
                    end
                end

                default: state_d = SEARCH;
            endcase
        end

        if (clr) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst_a, en_a, din_a, clr_a, locked_a, err_pulse_a;
    logic [31:0] err_count_a, bit_count_a;
    logic        rst_b, en_b, din_b, clr_b, locked_b, err_pulse_b;
    logic [3:0]  err_count_b, bit_count_b;

    logic [15:0] gen_a, gen_b;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit en;
        bit inv;
        bit clr;
        bit exp_locked;
        bit exp_pulse;
        int exp_err;
        int exp_bits;
    } vec_t;
    vec_t tbl [10];

    lfsr_checker dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .clr(clr_a),
        .locked(locked_a), .err_pulse(err_pulse_a),
        .err_count(err_count_a), .bit_count(bit_count_a)
    );

    lfsr_checker #(.LOCK_MATCHES(32), .LOSS_ERRORS(64), .LOSS_WINDOW(128), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .clr(clr_b),
        .locked(locked_b), .err_pulse(err_pulse_b),
        .err_count(err_count_b), .bit_count(bit_count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic gen_fb(input logic [15:0] s);
        return ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    endfunction

    task automatic raw_a(input bit e, input bit d, input bit c);
        en_a = e; din_a = d; clr_a = c;
        @(posedge clk); #1;
        en_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic step_a(input bit e, input bit inv, input bit c);
        logic b;
        b = gen_fb(gen_a);
        if (e) gen_a = {gen_a[14:0], b};
        raw_a(e, e ? (b ^ inv) : 1'b0, c);
    endtask

    task automatic step_b(input bit e, input bit inv, input bit c);
        logic b;
        b = gen_fb(gen_b);
        if (e) gen_b = {gen_b[14:0], b};
        en_b = e; din_b = e ? (b ^ inv) : 1'b0; clr_b = c;
        @(posedge clk); #1;
        en_b = 1'b0; clr_b = 1'b0;
    endtask

    initial begin
        int pulses;
        int unlocked;
        int lock_seen;
        int errs;

        tbl[0] = '{1, 0, 1, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 1, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 1, 1, 1, 2};
        tbl[4] = '{1, 0, 0, 1, 0, 1, 3};
        tbl[5] = '{0, 0, 0, 1, 0, 1, 3};
        tbl[6] = '{1, 1, 0, 1, 1, 2, 4};
        tbl[7] = '{0, 0, 0, 1, 0, 2, 4};
        tbl[8] = '{1, 0, 1, 1, 0, 0, 0};
        tbl[9] = '{1, 1, 1, 1, 1, 0, 0};

        rst_a = 1'b1; en_a = 1'b0; din_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; din_b = 1'b0; clr_b = 1'b0;
        gen_a = 16'h0001;
        gen_b = 16'h0001;
        #8;
        chk("rst_locked", locked_a, 0);
        chk("rst_pulse", err_pulse_a, 0);
        chk("rst_err", err_count_a, 0);
        chk("rst_bits", bit_count_a, 0);
        #4;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Clean stream: lock exactly on the 48th bit.
        for (int i = 1; i <= 48; i++) begin
            step_a(1, 0, 0);
            if (i >= 47) chk($sformatf("lock_edge_%0d", i), locked_a, (i == 48));
        end
        unlocked = 0;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step_a(1, 0, 0);
            if (err_pulse_a) pulses++;
            if (!locked_a) unlocked++;
        end
        chk("clean_pulses", pulses, 0);
        chk("clean_unlocked", unlocked, 0);
        chk("clean_bits", bit_count_a, 1000);
        chk("clean_err", err_count_a, 0);

        // Vector table: en gaps, single errors, clr priority.
        for (int i = 0; i < 10; i++) begin
            step_a(tbl[i].en, tbl[i].inv, tbl[i].clr);
            chk($sformatf("tbl%0d_locked", i), locked_a, tbl[i].exp_locked);
            chk($sformatf("tbl%0d_pulse", i), err_pulse_a, tbl[i].exp_pulse);
            chk($sformatf("tbl%0d_err", i), err_count_a, tbl[i].exp_err);
            chk($sformatf("tbl%0d_bits", i), bit_count_a, tbl[i].exp_bits);
        end

        // Errors do not corrupt the free-running register.
        pulses = 0;
        unlocked = 0;
        for (int i = 0; i < 100; i++) begin
            step_a(1, 0, 0);
            if (err_pulse_a) pulses++;
            if (!locked_a) unlocked++;
        end
        chk("post_err_pulses", pulses, 0);
        chk("post_err_unlocked", unlocked, 0);
        chk("post_err_count", err_count_a, 0);
        chk("post_err_bits", bit_count_a, 100);

        // Eight errors inside one window: lose lock on the 8th.
        step_a(1, 0, 1);
        errs = 0;
        for (int k = 0; k <= 28; k++) begin
            step_a(1, (k % 4 == 0), 0);
            if (k % 4 == 0) begin
                errs++;
                chk($sformatf("loss_err%0d_locked", errs), locked_a, (errs < 8));
            end
        end
        chk("loss_err_count", err_count_a, 8);
        chk("loss_bit_count", bit_count_a, 29);

        for (int i = 1; i <= 48; i++) begin
            step_a(1, 0, 0);
            if (i >= 47) chk($sformatf("relock_edge_%0d", i), locked_a, (i == 48));
        end
        chk("relock_bits", bit_count_a, 29);

        // Seven errors per window for ten windows: lock holds.
        unlocked = 0;
        for (int w = 0; w < 10; w++) begin
            for (int p = 0; p < 128; p++) begin
                step_a(1, (p >= 1 && p <= 61 && ((p - 1) % 10 == 0)), (w == 0 && p == 0));
                if (!locked_a) unlocked++;
            end
        end
        chk("win7_unlocked", unlocked, 0);
        chk("win7_err", err_count_a, 70);
        chk("win7_bits", bit_count_a, 1279);

        // Asynchronous reset while locked.
        #2 rst_a = 1'b1;
        #1;
        chk("arst_a_locked", locked_a, 0);
        chk("arst_a_err", err_count_a, 0);
        chk("arst_a_bits", bit_count_a, 0);
        chk("arst_a_pulse", err_pulse_a, 0);
        #1 rst_a = 1'b0;

        // Stuck-high input never locks; a fresh seed then does.
        lock_seen = 0;
        for (int i = 0; i < 500; i++) begin
            raw_a(1, 1, 0);
            if (locked_a) lock_seen++;
        end
        chk("ones_lock_seen", lock_seen, 0);
        gen_a = 16'h1234;
        for (int i = 0; i < 48; i++) step_a(1, 0, 0);
        chk("seed1234_locked", locked_a, 1);

        // Narrow counters: saturation and clr with coincident error.
        for (int i = 1; i <= 48; i++) step_a(0, 0, 0);
        for (int i = 1; i <= 48; i++) begin
            step_b(1, 0, 0);
            if (i >= 47) chk($sformatf("b_lock_edge_%0d", i), locked_b, (i == 48));
        end
        for (int k = 0; k < 100; k++) step_b(1, (k % 5 == 2), 0);
        chk("b_sat_err", err_count_b, 4'hF);
        chk("b_sat_bits", bit_count_b, 4'hF);
        chk("b_sat_locked", locked_b, 1);
        step_b(1, 1, 1);
        chk("b_clr_err", err_count_b, 0);
        chk("b_clr_bits", bit_count_b, 0);
        chk("b_clr_pulse", err_pulse_b, 1);
        chk("b_clr_locked", locked_b, 1);
        #2 rst_b = 1'b1;
        #1;
        chk("arst_b_locked", locked_b, 0);
        chk("arst_b_pulse", err_pulse_b, 0);
        chk("arst_b_err", err_count_b, 0);
        chk("arst_b_bits", bit_count_b, 0);
        #1 rst_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
